// File: rtl/dual_mode_buffer.sv
// dual_mode_buffer: one circular storage array that runs as a FIFO or a LIFO.
// The mode is chosen at run time through mode_sel and only changes while the
// buffer is empty. Read data falls through: out_data shows the next entry to
// be popped, or 0 while empty.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (push = in_valid & in_ready, pop = out_valid & out_ready).
// in_ready = ~full | out_ready, so a full buffer can take a word in the same
// cycle it gives one away. This is a combinational path from out_ready to
// in_ready; the producer must not make in_valid depend on in_ready.
//
// Optional build macro DMB_ERR_FLAGS_EN enables the sticky overflow and
// underflow flags. Without it, both flags are tied to 0 and err_clr is
// ignored.
module dual_mode_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 20,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } mode_t;

  mode_t                 mode_q, mode_d;
  logic [AW-1:0]         head_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  push, pop;
  logic [SW-1:0]         tail_sum, top_sum;
  logic [AW-1:0]         tail, top, rd_idx, wr_idx, head_inc;

  // Flags come only from the occupancy register.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign count        = count_q;

  assign in_ready  = ~full | out_ready;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Index arithmetic modulo DEPTH. The sums use one extra bit and are reduced
  // by a single conditional subtract. top is only used when count > 0.
  always_comb begin
    tail_sum = SW'(head_q) + SW'(count_q);
    tail     = (tail_sum >= SW'(DEPTH)) ? AW'(tail_sum - SW'(DEPTH)) : AW'(tail_sum);
    top_sum  = (count_q == '0) ? SW'(head_q) : (SW'(head_q) + SW'(count_q) - SW'(1));
    top      = (top_sum >= SW'(DEPTH)) ? AW'(top_sum - SW'(DEPTH)) : AW'(top_sum);
    head_inc = (head_q == AW'(DEPTH - 1)) ? '0 : head_q + AW'(1);
    rd_idx   = (mode_q == MODE_LIFO) ? top : head_q;
    // A LIFO push+pop replaces the top entry. A FIFO push+pop on a full
    // buffer writes the tail, which is the slot being vacated.
    wr_idx   = (pop && mode_q == MODE_LIFO) ? top : tail;
  end

  assign out_data = empty ? '0 : mem[rd_idx];

  // Mode next-state: follow mode_sel only while the buffer is empty.
  always_comb begin
    mode_d = mode_q;
    if (empty) mode_d = mode_t'(mode_sel);
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) mode_q <= MODE_FIFO;
    else     mode_q <= mode_d;
  end

  // Head pointer and occupancy update from the push/pop events.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop && mode_q == MODE_FIFO) head_q <= head_inc;
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage write. The array is not reset; a push during reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_idx] <= in_data;
  end

`ifdef DMB_ERR_FLAGS_EN
  // Sticky error flags. err_clr wins over a new set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready)   overflow  <= 1'b1;
      if (out_ready && !out_valid) underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dual_mode_buffer.sv
// Testbench for dual_mode_buffer (DEPTH=4, AFULL=3, AEMPTY=1, 8-bit data).
// A queue-based reference model tracks the expected contents. Directed
// sequences pin the model with hand-computed literal values.
module tb_dual_mode_buffer;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AFT = 3;
  localparam int AET = 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef DMB_ERR_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty;
  logic          err_clr = 1'b0;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Clock and DUT.
  always #5 clk = ~clk;

  dual_mode_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. exp_q holds the entries in arrival order, oldest first.
  logic [DW-1:0] exp_q[$];
  logic m_lifo = 1'b0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  always @(posedge clk) begin
    logic m_full, m_push, m_pop, was_empty;
    if (rst) begin
      exp_q.delete();
      m_lifo = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_empty = (exp_q.size() == 0);
      m_full = (exp_q.size() == DEPTH);
      m_push = in_valid && (!m_full || out_ready);
      m_pop = !was_empty && out_ready;
      if (FLAGS) begin
        if (err_clr) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end else begin
          if (in_valid && m_full && !out_ready) m_ovf = 1'b1;
          if (out_ready && was_empty) m_unf = 1'b1;
        end
      end
      if (m_push && m_pop) begin
        if (m_lifo) exp_q[exp_q.size() - 1] = in_data;
        else begin
          void'(exp_q.pop_front());
          exp_q.push_back(in_data);
        end
      end else if (m_pop) begin
        if (m_lifo) void'(exp_q.pop_back());
        else void'(exp_q.pop_front());
      end else if (m_push) begin
        exp_q.push_back(in_data);
      end
      if (was_empty) m_lifo = mode_sel;
    end
  end

  // Compare process: all outputs against the model on every cycle out of reset.
  always @(negedge clk) begin
    logic [DW-1:0] e_data;
    int n;
    if (chk_en && !rst) begin
      n = exp_q.size();
      e_data = (n == 0) ? '0 : (m_lifo ? exp_q[n - 1] : exp_q[0]);
      chk("m_count", 32'(count), 32'(n));
      chk("m_out_valid", 32'(out_valid), 32'(n != 0));
      chk("m_out_data", 32'(out_data), 32'(e_data));
      chk("m_full", 32'(full), 32'(n == DEPTH));
      chk("m_empty", 32'(empty), 32'(n == 0));
      chk("m_afull", 32'(almost_full), 32'(n >= AFT));
      chk("m_aempty", 32'(almost_empty), 32'(n <= AET));
      chk("m_in_ready", 32'(in_ready), 32'((n != DEPTH) || out_ready));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // Driver tasks: apply inputs, then let one rising edge pass.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Transfer cycle whose out_data is checked before the edge.
  task automatic xfer(input string name, input logic iv, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp);
    in_valid = iv;
    in_data = d;
    out_ready = 1'b1;
    @(negedge clk);
    chk(name, 32'(out_data), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then the idle state.
    repeat (3) step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk_en = 1'b1;

    // FIFO fill and drain.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("fifo_afull_at3", 32'(almost_full), 32'd1);
    chk("fifo_not_full_at3", 32'(full), 32'd0);
    step(1'b1, 8'h44, 1'b0);
    chk("fifo_full", 32'(full), 32'd1);
    chk("fifo_count4", 32'(count), 32'd4);
    xfer("fifo_pop1", 1'b0, 8'h00, 8'h11);
    xfer("fifo_pop2", 1'b0, 8'h00, 8'h22);
    xfer("fifo_pop3", 1'b0, 8'h00, 8'h33);
    xfer("fifo_pop4", 1'b0, 8'h00, 8'h44);
    chk("fifo_drained", 32'(empty), 32'd1);

    // FIFO across the wrap point.
    step(1'b1, 8'h51, 1'b0);
    step(1'b1, 8'h52, 1'b0);
    step(1'b1, 8'h53, 1'b0);
    xfer("wrap_pop51", 1'b0, 8'h00, 8'h51);
    step(1'b1, 8'h54, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    xfer("wrap_pop52", 1'b0, 8'h00, 8'h52);
    xfer("wrap_pop53", 1'b0, 8'h00, 8'h53);
    xfer("wrap_pop54", 1'b0, 8'h00, 8'h54);
    xfer("wrap_pop55", 1'b0, 8'h00, 8'h55);

    // LIFO ordering.
    mode_sel = 1'b1;
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    xfer("lifo_popA3", 1'b0, 8'h00, 8'hA3);
    xfer("lifo_popA2", 1'b0, 8'h00, 8'hA2);
    xfer("lifo_popA1", 1'b0, 8'h00, 8'hA1);
    chk("lifo_empty", 32'(empty), 32'd1);

    // Full FIFO, push and pop in the same cycle.
    mode_sel = 1'b0;
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    xfer("fifo_full_pp", 1'b1, 8'h05, 8'h01);
    chk("fifo_pp_count", 32'(count), 32'd4);
    xfer("fifo_pp_pop2", 1'b0, 8'h00, 8'h02);
    xfer("fifo_pp_pop3", 1'b0, 8'h00, 8'h03);
    xfer("fifo_pp_pop4", 1'b0, 8'h00, 8'h04);
    xfer("fifo_pp_pop5", 1'b0, 8'h00, 8'h05);

    // Full LIFO, push and pop in the same cycle replaces the top entry.
    mode_sel = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    xfer("lifo_full_pp", 1'b1, 8'h09, 8'h04);
    chk("lifo_pp_count", 32'(count), 32'd4);
    xfer("lifo_pp_pop9", 1'b0, 8'h00, 8'h09);
    xfer("lifo_pp_pop3", 1'b0, 8'h00, 8'h03);
    xfer("lifo_pp_pop2", 1'b0, 8'h00, 8'h02);
    xfer("lifo_pp_pop1", 1'b0, 8'h00, 8'h01);

    // A mode request while non-empty waits until the buffer drains.
    mode_sel = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    mode_sel = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    xfer("msw_pop61", 1'b0, 8'h00, 8'h61);
    xfer("msw_pop62", 1'b0, 8'h00, 8'h62);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h71, 1'b0);
    step(1'b1, 8'h72, 1'b0);
    xfer("msw_pop72", 1'b0, 8'h00, 8'h72);
    xfer("msw_pop71", 1'b0, 8'h00, 8'h71);

    // Sticky error flags.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(overflow), 32'(FLAGS));
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_held", 32'(overflow), 32'(FLAGS));
    err_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    xfer("err_pop84", 1'b0, 8'h00, 8'h84);
    xfer("err_pop83", 1'b0, 8'h00, 8'h83);
    xfer("err_pop82", 1'b0, 8'h00, 8'h82);
    xfer("err_pop81", 1'b0, 8'h00, 8'h81);
    step(1'b0, 8'h00, 1'b1);
    chk("unf_set", 32'(underflow), 32'(FLAGS));
    step(1'b0, 8'h00, 1'b0);
    chk("unf_held", 32'(underflow), 32'(FLAGS));
    err_clr = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    err_clr = 1'b0;
    chk("unf_clr_priority", 32'(underflow), 32'd0);

    // Reset in the middle of traffic drops contents and the concurrent push.
    step(1'b1, 8'h91, 1'b0);
    step(1'b1, 8'h92, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h93, 1'b1);
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    step(1'b1, 8'hB1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("midrst_latency", 32'(out_data), 32'hB1);
    xfer("midrst_popB1", 1'b0, 8'h00, 8'hB1);
    step(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_mode_buffer.md
Name: dual_mode_buffer

Overview:
Parametrised storage buffer that runs as a FIFO (queue) or a LIFO (stack) from a single circular storage array.
- Valid/ready handshakes on both the write and read sides.
- First-word-fall-through read data.
- Occupancy count plus almost-full and almost-empty flags.
- Sits between a producer and a consumer that need queue or stack ordering, selected at run time.

Parameters:
- DATA_WIDTH, 8: width of each entry in bits.
- DEPTH, 20: number of entries; legal range DEPTH >= 2.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_sel  in  1  requested mode: 0 = FIFO, 1 = LIFO.
- in_valid  in  1  producer has data.
- in_ready  out  1  buffer accepts data.
- in_data  in  DATA_WIDTH  write data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes data.
- out_data  out  DATA_WIDTH  read data.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a write was attempted while in_ready was low.
- underflow  out  1  sticky: a read was attempted while out_valid was low.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset state:
  - head = 0, count = 0, active_mode = 0 (FIFO), overflow = 0, underflow = 0.
  - Storage array is not reset.
  - Outputs after reset: empty = 1, full = 0, out_valid = 0, out_data = 0, in_ready = 1, almost_empty = 1, almost_full = 0.
- A reset asserted mid-traffic discards all contents in that same cycle; any push or pop in that cycle is ignored.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Ready/valid:
  - in_ready = ~full | out_ready. This is a combinational path from out_ready to in_ready; the producer must not make in_valid depend on in_ready.
  - out_valid = ~empty.
- Indexing: all index arithmetic is modulo DEPTH, computed with one-bit-wider intermediates and a conditional subtract of DEPTH (no % operator).
  - tail = (head + count) mod DEPTH.
  - top = (head + count - 1) mod DEPTH.
- FIFO mode:
  - out_data = mem[head].
  - Push writes mem[tail], count + 1.
  - Pop advances head (wrapping DEPTH-1 -> 0), count - 1.
  - Push and pop together: write mem[tail], head advances, count unchanged. This is legal when full; tail then equals the slot being vacated.
- LIFO mode:
  - out_data = mem[top].
  - Push writes mem[tail], count + 1.
  - Pop gives count - 1; head unchanged.
  - Push and pop together: write mem[top] (replace the top entry), count unchanged. The consumer receives the old top that cycle.
- Empty buffer: out_valid = 0, so no pop occurs and out_data is driven to 0. A push in the same cycle is a push only.
- Latency: data pushed into an empty buffer appears on out_data with out_valid = 1 one cycle after the push edge.
- Mode switching:
  - active_mode <= mode_sel only on cycles where empty = 1 before the edge.
  - mode_sel changes while non-empty have no effect until the buffer drains.
  - A push in the switch cycle is legal; with one entry both modes behave identically.
- Flags: full, empty, almost_full, almost_empty and count derive from the count register only; all update on the edge after the event.

Optional Feature:
Macro DMB_ERR_FLAGS_EN.
- Defined:
  - overflow sets when in_valid & ~in_ready.
  - underflow sets when out_ready & ~out_valid.
  - Both flags hold until err_clr = 1 or rst = 1. err_clr has priority over a new set in the same cycle.
- Undefined:
  - overflow and underflow are tied to 0; err_clr is ignored.
  - The ports remain present so the interface is identical in both builds.

Test Plan:
- Test configuration: DEPTH = 4, AFULL_THRESH = 3, AEMPTY_THRESH = 1, DATA_WIDTH = 8.
- Reset, then idle -> empty = 1, count = 0, out_valid = 0, out_data = 0, in_ready = 1, almost_empty = 1.
- FIFO: push 0x11, 0x22, 0x33, 0x44 -> full = 1, almost_full = 1 from count 3. Pop four times -> 0x11, 0x22, 0x33, 0x44. Then push 5 more / pop 5 more to cross the wrap and check order is preserved.
- LIFO (mode_sel = 1 while empty): push 0xA1, 0xA2, 0xA3 -> pops return 0xA3, 0xA2, 0xA1. Then empty = 1.
- Full with simultaneous push and pop:
  - FIFO holding 1,2,3,4, push 5 with pop -> out = 1, count stays 4, next pops 2,3,4,5.
  - LIFO holding 1,2,3,4, push 9 with pop -> out = 4, next pops 9,3,2,1.
- Mode change while count = 2 -> active mode unchanged and pop order stays FIFO; after draining to empty, the new mode takes effect.
- With DMB_ERR_FLAGS_EN:
  - in_valid while full and out_ready = 0 -> overflow = 1, held.
  - out_ready while empty -> underflow = 1.
  - err_clr -> both 0 next cycle.
  - Without the macro, the same stimulus leaves both flags at 0.
